// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, one bit per clock, LSB first.
// Each bit is built from two half_adder cells and an OR, with the carry held in a flip-flop.
// The sum and carry-out are held until the consumer acknowledges.
// Optional feature macro: SERIAL_ADDER_SUBTRACT_EN adds a `sub` input for A-B.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
`ifdef SERIAL_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ack,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // The counter only needs to reach WIDTH-1; keep it at least one bit wide.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;

  // Subtract select: complement B and inject a carry-in of 1 when set.
  logic sub_sel;
`ifdef SERIAL_ADDER_SUBTRACT_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // One full-adder slice: two half adders, carries merged with an OR.
  logic p_bit, g0_bit, g1_bit, sum_bit, carry_next;

  half_adder u_ha_ab (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .s_o (p_bit),
    .c_o (g0_bit)
  );

  half_adder u_ha_pc (
    .a_i (p_bit),
    .b_i (carry_q),
    .s_o (sum_bit),
    .c_o (g1_bit)
  );

  assign carry_next = g0_bit | g1_bit;

  // State, counter, operand/result shift registers and carry flip-flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  // Next-state logic: accept in IDLE, one bit per cycle in RUN, hold in DONE until ack.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = input_a;
          b_d     = input_b ^ {WIDTH{sub_sel}};
          carry_d = sub_sel;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d             = a_q >> 1;
        b_d             = b_q >> 1;
        res_d           = res_q >> 1;
        res_d[WIDTH-1]  = sum_bit;
        carry_d         = carry_next;
        if (count_q == LAST_BIT) begin
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        // A start arriving together with the ack is deliberately dropped.
        if (result_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready        = (state_q == IDLE);
  assign busy         = (state_q == RUN);
  assign result_valid = (state_q == DONE);
  assign sum          = res_q;
  assign carry        = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: self-checking bench for serial_adder_ctrl (WIDTH=8).
// Expected results come from plain integer arithmetic on the operands.
// Subtract scenarios are compiled only with SERIAL_ADDER_SUBTRACT_EN.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic         sub;
  logic         ready;
  logic         busy;
  logic         result_valid;
  logic         result_ack;
  logic [W-1:0] sum;
  logic         carry;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .input_a      (input_a),
    .input_b      (input_b),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .sub          (sub),
`endif
    .ready        (ready),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .sum          (sum),
    .carry        (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge (waits for ready, bounded).
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    n = 0;
    while (!ready && n < 50) begin
      tick();
      n++;
    end
    start   = 1'b1;
    input_a = a;
    input_b = b;
    sub     = s;
    tick();
    start   = 1'b0;
    input_a = W'($urandom);
    input_b = W'($urandom);
    sub     = 1'($urandom);
  endtask

  // Count cycles after the accept edge until result_valid is seen (bounded).
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!result_valid && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, busy, result_valid, sum, carry} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b busy=%b valid=%b sum=%h carry=%b, want 1 0 0 00 0",
               ready, busy, result_valid, sum, carry);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b, want 1 0", ready, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int cyc;
    accept_op(8'h35, 8'h4A, 1'b0);
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got busy=%b ready=%b, want 1 0", busy, ready);
    end
    wait_valid(cyc);
    checks++;
    if (cyc !== W) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, want %0d", cyc, W);
    end
    checks++;
    if (sum !== 8'h7F || carry !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: got sum=%h carry=%b, want 7f 0", sum, carry);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    checks++;
    if (ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: got ready=%b valid=%b, want 1 0", ready, result_valid);
    end
    $display("test_basic 35+4a sum=%h carry=%b latency=%0d", sum, carry, cyc);
  endtask

  task automatic test_carry_ripple();
    int cyc;
    accept_op(8'hFF, 8'h01, 1'b0);
    wait_valid(cyc);
    checks++;
    if (sum !== 8'h00 || carry !== 1'b1 || cyc !== W) begin
      errors++;
      $display("FAIL ripple: got sum=%h carry=%b lat=%0d, want 00 1 %0d", sum, carry, cyc, W);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    $display("test_carry_ripple ff+01 sum=%h carry=%b", sum, carry);
  endtask

  task automatic test_ignore_start();
    int cyc;
    int extra_valid;
    accept_op(8'h0F, 8'h01, 1'b0);
    tick();
    tick();
    start   = 1'b1;
    input_a = 8'hAA;
    input_b = 8'h55;
    tick();
    start   = 1'b0;
    wait_valid(cyc);
    checks++;
    if (sum !== 8'h10 || carry !== 1'b0 || cyc !== W - 3) begin
      errors++;
      $display("FAIL ignore_start: got sum=%h carry=%b wait=%0d, want 10 0 %0d", sum, carry, cyc, W - 3);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    extra_valid = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (result_valid || busy) extra_valid++;
      tick();
    end
    checks++;
    if (extra_valid !== 0) begin
      errors++;
      $display("FAIL dropped_request: got %0d busy/valid cycles after ack, want 0", extra_valid);
    end
    $display("test_ignore_start 0f+01 sum=%h carry=%b", sum, carry);
  endtask

  task automatic test_hold_done();
    int cyc;
    logic [W-1:0] a2, b2;
    logic [W:0]   exp2;
    accept_op(8'hC3, 8'h7E, 1'b0);
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      start   = 1'b1;
      input_a = W'($urandom);
      input_b = W'($urandom);
      tick();
      checks++;
      if (result_valid !== 1'b1 || sum !== 8'h41 || carry !== 1'b1) begin
        errors++;
        $display("FAIL hold_done[%0d]: got valid=%b sum=%h carry=%b, want 1 41 1",
                 i, result_valid, sum, carry);
      end
    end
    a2 = W'($urandom);
    b2 = W'($urandom);
    exp2 = {1'b0, a2} + {1'b0, b2};
    start      = 1'b1;
    result_ack = 1'b1;
    input_a    = a2;
    input_b    = b2;
    tick();
    result_ack = 1'b0;
    checks++;
    if (ready !== 1'b1 || result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_with_start: got ready=%b valid=%b busy=%b, want 1 0 0", ready, result_valid, busy);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_after_ack: got busy=%b, want 1", busy);
    end
    wait_valid(cyc);
    checks++;
    if ({carry, sum} !== exp2 || cyc !== W) begin
      errors++;
      $display("FAIL post_ack_add: got %h lat=%0d, want %h lat=%0d", {carry, sum}, cyc, exp2, W);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    $display("test_hold_done c3+7e then %h+%h -> %h", a2, b2, exp2);
  endtask

  task automatic test_midrun_reset();
    int seen;
    accept_op(8'h5A, 8'h3C, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, busy, result_valid, sum, carry} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset: got ready=%b busy=%b valid=%b sum=%h carry=%b, want 1 0 0 00 0",
               ready, busy, result_valid, sum, carry);
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (result_valid || !ready) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrun_no_valid: got %0d non-idle cycles, want 0", seen);
    end
    $display("test_midrun_reset done");
  endtask

  task automatic test_random();
    int cyc;
    logic [W-1:0] a, b;
    logic [W:0]   exp;
    for (int t = 0; t < 20; t++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      exp = {1'b0, a} + {1'b0, b};
      accept_op(a, b, 1'b0);
      start = 1'($urandom);
      wait_valid(cyc);
      start = 1'b0;
      checks++;
      if ({carry, sum} !== exp || cyc !== W) begin
        errors++;
        $display("FAIL random[%0d]: %h+%h got %h lat=%0d, want %h lat=%0d", t, a, b, {carry, sum}, cyc, exp, W);
      end else begin
        $display("random[%0d] %h+%h = %h", t, a, b, exp);
      end
      repeat ($urandom_range(0, 3)) tick();
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
    end
  endtask

`ifdef SERIAL_ADDER_SUBTRACT_EN
  task automatic test_subtract();
    int cyc;
    logic [W-1:0] a, b;
    logic [W-1:0] exp_s;
    logic         exp_c;
    for (int t = 0; t < 8; t++) begin
      if (t == 0) begin a = 8'h10; b = 8'h01; end
      else if (t == 1) begin a = 8'h01; b = 8'h02; end
      else begin a = W'($urandom); b = W'($urandom); end
      exp_s = W'(int'(a) - int'(b));
      exp_c = (a >= b);
      accept_op(a, b, 1'b1);
      wait_valid(cyc);
      checks++;
      if (sum !== exp_s || carry !== exp_c) begin
        errors++;
        $display("FAIL subtract[%0d]: %h-%h got sum=%h carry=%b, want %h %b", t, a, b, sum, carry, exp_s, exp_c);
      end else begin
        $display("subtract[%0d] %h-%h = %h carry=%b", t, a, b, exp_s, exp_c);
      end
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
    end
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    result_ack = 1'b0;
    input_a    = '0;
    input_b    = '0;
    sub        = 1'b0;
    test_reset();
    test_basic();
    test_carry_ripple();
    test_ignore_start();
    test_hold_done();
    test_midrun_reset();
    test_random();
`ifdef SERIAL_ADDER_SUBTRACT_EN
    test_subtract();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
